// File: rtl/fp_add_responder_if.sv
// fp_add_responder_if: add request/response handshake between a sequencer (master) and the shared adder (slave).
interface fp_add_responder_if #(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23
);
    localparam int W = EXP_LEN + MANTISSA_LEN + 1;

    logic         add_start;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] add_sum;
    logic         add_ready;
    logic         add_busy;

    modport master (
        output add_start, add_a, add_b,
        input  add_sum, add_ready, add_busy
    );

    modport slave (
        input  add_start, add_a, add_b,
        output add_sum, add_ready, add_busy
    );
endinterface

// File: rtl/fp_add_responder.sv
// fp_add_responder: multi-cycle floating-point adder (align, add, normalise, round), no subnormals.
// Define FP_ADD_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fp_add_responder #(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23
) (
    input  logic              clock,
    input  logic              reset_n,
    fp_add_responder_if.slave bus
);
    localparam int W   = EXP_LEN + MANTISSA_LEN + 1;
    localparam int SW  = MANTISSA_LEN + 4;
    localparam int XW  = EXP_LEN + 2;
    localparam int LZW = $clog2(SW + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ALIGN = 3'd1;
    localparam logic [2:0] ADD   = 3'd2;
    localparam logic [2:0] NORM  = 3'd3;
    localparam logic [2:0] ROUND = 3'd4;

    localparam logic [EXP_LEN-1:0]   EXP_ONES  = '1;
    localparam logic [EXP_LEN-1:0]   MAX_SHIFT = EXP_LEN'(SW - 1);
    localparam logic [W-1:0]         QNAN      = {1'b0, EXP_ONES, 1'b1, {(MANTISSA_LEN-1){1'b0}}};
    localparam logic signed [XW-1:0] EXP_INF   = $signed({2'b00, EXP_ONES});
    localparam logic signed [XW-1:0] EXP_ONE   = 1;

    logic [2:0]           state;
    logic [W-1:0]         op_a, op_b;
    logic                 special;
    logic [W-1:0]         special_val;
    logic                 sign_big, sign_small;
    logic signed [XW-1:0] exp_big;
    logic [SW-1:0]        sig_big, sig_small;
    logic [SW:0]          sum_mag;
    logic                 res_sign, res_zero;
    logic signed [XW-1:0] res_exp;
    logic [SW-1:0]        norm_sig;

    logic [EXP_LEN-1:0]      exp_a, exp_b, big_exp, small_exp, diff;
    logic [MANTISSA_LEN-1:0] frac_a, frac_b, big_frac, small_frac;
    logic                    zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic                    a_big, big_zero, small_zero, big_s, small_s;
    logic [W-2:0]            mag_a, mag_b;
    logic [SW-1:0]           big_sig_c, small_sig_c, shifted, lost_mask;
    logic                    special_c;
    logic [W-1:0]            special_val_c;

    assign exp_a  = op_a[W-2:MANTISSA_LEN];
    assign exp_b  = op_b[W-2:MANTISSA_LEN];
    assign frac_a = op_a[MANTISSA_LEN-1:0];
    assign frac_b = op_b[MANTISSA_LEN-1:0];
    assign zero_a = (exp_a == '0);
    assign zero_b = (exp_b == '0);
    assign inf_a  = (exp_a == EXP_ONES) && (frac_a == '0);
    assign inf_b  = (exp_b == EXP_ONES) && (frac_b == '0);
    assign nan_a  = (exp_a == EXP_ONES) && (frac_a != '0);
    assign nan_b  = (exp_b == EXP_ONES) && (frac_b != '0);
    assign mag_a  = zero_a ? '0 : op_a[W-2:0];
    assign mag_b  = zero_b ? '0 : op_b[W-2:0];
    assign a_big  = (mag_a >= mag_b);

    // Order operands by magnitude and align the smaller one, folding shifted-out bits into sticky.
    always_comb begin
        big_exp     = a_big ? exp_a : exp_b;
        small_exp   = a_big ? exp_b : exp_a;
        big_frac    = a_big ? frac_a : frac_b;
        small_frac  = a_big ? frac_b : frac_a;
        big_zero    = a_big ? zero_a : zero_b;
        small_zero  = a_big ? zero_b : zero_a;
        big_s       = a_big ? op_a[W-1] : op_b[W-1];
        small_s     = a_big ? op_b[W-1] : op_a[W-1];
        big_sig_c   = big_zero ? '0 : {1'b1, big_frac, 3'b000};
        small_sig_c = small_zero ? '0 : {1'b1, small_frac, 3'b000};
        diff        = big_exp - small_exp;
        lost_mask   = '0;
        if (diff >= MAX_SHIFT) begin
            shifted = {{(SW-1){1'b0}}, |small_sig_c};
        end else begin
            shifted    = small_sig_c >> diff;
            lost_mask  = ~({SW{1'b1}} << diff);
            shifted[0] = shifted[0] | (|(small_sig_c & lost_mask));
        end
    end

    always_comb begin
        special_c     = 1'b1;
        special_val_c = '0;
        if (nan_a || nan_b || (inf_a && inf_b && (op_a[W-1] != op_b[W-1]))) begin
            special_val_c = QNAN;
        end else if (inf_a) begin
            special_val_c = op_a;
        end else if (inf_b) begin
            special_val_c = op_b;
        end else if (zero_a && zero_b) begin
            special_val_c = {op_a[W-1] & op_b[W-1], {(W-1){1'b0}}};
        end else begin
            special_c = 1'b0;
        end
    end

    logic [LZW-1:0]       lzc;
    logic [SW-1:0]        shift_sig;
    logic signed [XW-1:0] shift_exp;

    always_comb begin
        lzc = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (sum_mag[i]) lzc = LZW'(SW - 1 - i);
        end
    end

    assign shift_sig = sum_mag[SW-1:0] << lzc;
    assign shift_exp = exp_big - $signed(XW'(lzc));

    logic                    inc;
    logic [MANTISSA_LEN+1:0] rounded;
    logic signed [XW-1:0]    rnd_exp;
    logic [MANTISSA_LEN-1:0] rnd_frac;

`ifdef FP_ADD_RNE_EN
    assign inc = norm_sig[2] & (norm_sig[1] | norm_sig[0] | norm_sig[3]);
`else
    logic grs_unused;
    assign grs_unused = ^norm_sig[2:0];
    assign inc        = 1'b0;
`endif

    assign rounded  = {1'b0, norm_sig[SW-1:3]} + {{(MANTISSA_LEN+1){1'b0}}, inc};
    assign rnd_exp  = res_exp + $signed({{(XW-1){1'b0}}, rounded[MANTISSA_LEN+1]});
    assign rnd_frac = rounded[MANTISSA_LEN+1] ? rounded[MANTISSA_LEN:1] : rounded[MANTISSA_LEN-1:0];

    // One pipeline step per state; specials ride alongside untouched until ROUND.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            op_a          <= '0;
            op_b          <= '0;
            special       <= 1'b0;
            special_val   <= '0;
            sign_big      <= 1'b0;
            sign_small    <= 1'b0;
            exp_big       <= '0;
            sig_big       <= '0;
            sig_small     <= '0;
            sum_mag       <= '0;
            res_sign      <= 1'b0;
            res_zero      <= 1'b0;
            res_exp       <= '0;
            norm_sig      <= '0;
            bus.add_sum   <= '0;
            bus.add_ready <= 1'b0;
            bus.add_busy  <= 1'b0;
        end else begin
            bus.add_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.add_start) begin
                        op_a         <= bus.add_a;
                        op_b         <= bus.add_b;
                        bus.add_busy <= 1'b1;
                        state        <= ALIGN;
                    end
                end
                ALIGN: begin
                    special     <= special_c;
                    special_val <= special_val_c;
                    sign_big    <= big_s;
                    sign_small  <= small_s;
                    exp_big     <= $signed({2'b00, big_exp});
                    sig_big     <= big_sig_c;
                    sig_small   <= shifted;
                    state       <= ADD;
                end
                ADD: begin
                    sum_mag <= (sign_big == sign_small) ? ({1'b0, sig_big} + {1'b0, sig_small})
                                                        : ({1'b0, sig_big} - {1'b0, sig_small});
                    state   <= NORM;
                end
                NORM: begin
                    if (sum_mag[SW]) begin
                        norm_sig <= {sum_mag[SW:2], |sum_mag[1:0]};
                        res_exp  <= exp_big + EXP_ONE;
                        res_sign <= sign_big;
                        res_zero <= 1'b0;
                    end else if (sum_mag == '0) begin
                        res_sign <= 1'b0;
                        res_zero <= 1'b1;
                    end else if (shift_exp[XW-1] || (shift_exp == '0)) begin
                        res_sign <= sign_big;
                        res_zero <= 1'b1;
                    end else begin
                        norm_sig <= shift_sig;
                        res_exp  <= shift_exp;
                        res_sign <= sign_big;
                        res_zero <= 1'b0;
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    if (special) begin
                        bus.add_sum <= special_val;
                    end else if (res_zero) begin
                        bus.add_sum <= {res_sign, {(W-1){1'b0}}};
                    end else if (rnd_exp >= EXP_INF) begin
                        bus.add_sum <= {res_sign, EXP_ONES, {MANTISSA_LEN{1'b0}}};
                    end else begin
                        bus.add_sum <= {res_sign, rnd_exp[EXP_LEN-1:0], rnd_frac};
                    end
                    bus.add_ready <= 1'b1;
                    bus.add_busy  <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_responder.sv
// tb_fp_add_responder: scoreboard bench for fp_add_responder using directed binary32 vectors.
module tb_fp_add_responder;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   bad     = 0;
    logic [31:0] exp_q[$];

`ifdef FP_ADD_RNE_EN
    localparam logic [31:0] ROUND_EXP = 32'h3F800002;
`else
    localparam logic [31:0] ROUND_EXP = 32'h3F800001;
`endif

    fp_add_responder_if #(.EXP_LEN(8), .MANTISSA_LEN(23)) bus ();

    fp_add_responder #(.EXP_LEN(8), .MANTISSA_LEN(23)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every ready pulse consumes the oldest expected result.
    always @(negedge clock) begin
        if (reset_n && bus.add_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected ready: got sum %h expected no pulse", bus.add_sum);
            end else begin
                checkOutput("sum", bus.add_sum, exp_q.pop_front());
            end
        end
    end

    // Caller is at a negedge; measures cycles to ready and busy duration.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] expected, input string name);
        int  cyc;
        int  busy_cyc;
        bit  seen;
        bus.add_start = 1'b1;
        bus.add_a     = a;
        bus.add_b     = b;
        exp_q.push_back(expected);
        cyc      = 0;
        busy_cyc = 0;
        seen     = 0;
        while (!seen && cyc < 20) begin
            @(negedge clock);
            bus.add_start = 1'b0;
            cyc++;
            if (bus.add_busy) busy_cyc++;
            if (bus.add_ready) seen = 1;
        end
        checkOutput({name, " latency"}, 32'(cyc), 32'd5);
        checkOutput({name, " busy"}, 32'(busy_cyc), 32'd4);
    endtask

    task automatic checkIdle(input logic [31:0] expected, input string name);
        @(negedge clock);
        checkOutput({name, " ready low"}, {31'd0, bus.add_ready}, 32'd0);
        checkOutput({name, " sum held"}, bus.add_sum, expected);
    endtask

    task automatic countPulses(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (bus.add_ready) pulses++;
        end
    endtask

    initial begin
        int pulses;
        bus.add_start = 1'b0;
        bus.add_a     = '0;
        bus.add_b     = '0;
        reset_n       = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset sum", bus.add_sum, 32'd0);
        checkOutput("reset ready", {31'd0, bus.add_ready}, 32'd0);
        checkOutput("reset busy", {31'd0, bus.add_busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        applyStimulus(32'h3F800000, 32'h40000000, 32'h40400000, "1+2");
        checkIdle(32'h40400000, "1+2");

        applyStimulus(32'h40490FDB, 32'hC0C90FDB, 32'hC0490FDB, "pi-2pi");
        applyStimulus(32'h3F800000, 32'hBF800000, 32'h00000000, "1-1 b2b");
        checkIdle(32'h00000000, "1-1");

        applyStimulus(32'h3F800000, 32'h34400000, ROUND_EXP, "round");
        applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, "overflow");
        applyStimulus(32'h7F800000, 32'hFF800000, 32'h7FC00000, "inf-inf");
        applyStimulus(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan");
        applyStimulus(32'hFF800000, 32'h3F800000, 32'hFF800000, "-inf+1");
        applyStimulus(32'h80000000, 32'h80000000, 32'h80000000, "-0+-0");
        applyStimulus(32'h3F800000, 32'h00000000, 32'h3F800000, "1+0");
        checkIdle(32'h3F800000, "1+0");

        bus.add_start = 1'b1;
        bus.add_a     = 32'h3F800000;
        bus.add_b     = 32'h40000000;
        exp_q.push_back(32'h40400000);
        @(negedge clock);
        bus.add_start = 1'b0;
        @(negedge clock);
        bus.add_start = 1'b1;
        bus.add_a     = 32'h3F800000;
        bus.add_b     = 32'h3F800000;
        @(negedge clock);
        bus.add_start = 1'b0;
        countPulses(12, pulses);
        checkOutput("busy ignore pulses", 32'(pulses), 32'd1);

        bus.add_start = 1'b1;
        bus.add_a     = 32'h3F800000;
        bus.add_b     = 32'h3F800000;
        @(negedge clock);
        bus.add_start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        checkOutput("abort sum", bus.add_sum, 32'd0);
        checkOutput("abort busy", {31'd0, bus.add_busy}, 32'd0);
        countPulses(10, pulses);
        checkOutput("abort pulses", 32'(pulses), 32'd0);

        applyStimulus(32'h3FC00000, 32'h3FC00000, 32'h40400000, "1.5+1.5");
        checkIdle(32'h40400000, "1.5+1.5");

        repeat (3) @(negedge clock);
        checkOutput("queue empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/fp_add_responder.md
Name: fp_add_responder

Overview:
- Multi-cycle floating-point adder. It is the responder side of the add handshake that the angle normalization and angle wrapper blocks initiate.
- Accepts operand pair + start pulse, returns sum + one-cycle ready pulse.
- Shared by sequencers that time-multiplex one adder. Parameterised sign/exponent/mantissa format, IEEE-754-like, no subnormals.

Parameters:
EXP_LEN, 8, exponent field width (bias = 2^(EXP_LEN-1)-1)
MANTISSA_LEN, 23, stored fraction width (hidden bit implied)

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  synchronous reset, active low
add_start  input  1  request strobe; sampled only in IDLE
add_a  input  EXP_LEN+MANTISSA_LEN+1  operand A {sign, exp, frac}
add_b  input  EXP_LEN+MANTISSA_LEN+1  operand B
add_sum  output  EXP_LEN+MANTISSA_LEN+1  result, held until next result
add_ready  output  1  one-cycle pulse: add_sum valid
add_busy  output  1  high from acceptance until ready pulse

Behaviour:
- Reset (reset_n=0 at an edge): state IDLE; add_sum=0, add_ready=0, add_busy=0; internal operand/intermediate regs cleared. Reset mid-operation aborts it; no ready pulse is ever issued for the aborted request.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> IDLE, one state per clock, no stalls.
- IDLE: if add_start=1, latch add_a/add_b, go to ALIGN, add_busy<=1. add_start outside IDLE is ignored; requests are not queued.
- ALIGN: unpack operands; exp field 0 => operand is zero (flush-to-zero). Swap so the larger magnitude is first. Right-shift the smaller significand by the exponent difference into a MANTISSA_LEN+4-bit significand (hidden + frac + guard, round, sticky). The sticky bit ORs all shifted-out bits. A difference >= MANTISSA_LEN+3 leaves only sticky.
- ADD: equal signs => add magnitudes, else subtract smaller from larger; result sign = sign of the larger magnitude.
- NORM: carry-out => shift right 1, exp+1, sticky retained. Otherwise leading-zero count (combinational) => shift left, exp-count. Exact-zero magnitude => result +0. Exponent falling to <=0 => signed zero.
- ROUND: apply the rounding mode (see Optional Feature). Mantissa overflow from rounding => exp+1. Exp >= all-ones => infinity with result sign. Result is registered into add_sum; add_ready<=1, add_busy<=0, state IDLE.
- Latency: add_start sampled at edge N; add_sum/add_ready updated at edge N+4; add_ready high for exactly one cycle.
- Back-to-back: add_start high in the ready cycle is accepted (state is IDLE), giving one result every 5 cycles.
- Specials, decided in ALIGN and bypassing arithmetic, with the same 4-cycle latency:
  - any NaN => canonical quiet NaN (sign 0, exp all-ones, frac MSB=1, rest 0);
  - +inf + -inf => canonical NaN;
  - one infinity => that infinity;
  - both zero => -0 only if both -0, else +0.
- add_sum is never changed except on a ready pulse or reset.

Optional Feature:
- FP_ADD_RNE_EN defined: round-to-nearest-even using guard/round/sticky. Increment if G=1 and (R|S|LSB)=1.
- FP_ADD_RNE_EN undefined: round toward zero (truncate G/R/S).
- Latency, handshake and overflow-to-infinity are identical in both builds.

Test Plan:
- Reset, then add_a=0x3F800000 (1.0), add_b=0x40000000 (2.0), add_start 1 cycle -> add_busy high 4 cycles; add_ready pulse exactly 4 edges later; add_sum=0x40400000 (3.0).
- add_a=0x40490FDB (pi), add_b=0xC0C90FDB (-2pi) -> add_sum=0xC0490FDB. Then 0x3F800000 + 0xBF800000 -> add_sum=0x00000000.
- add_a=0x3F800000, add_b=0x34400000 (3*2^-24) -> add_sum=0x3F800002 with FP_ADD_RNE_EN, 0x3F800001 without.
- 0x7F7FFFFF + 0x7F7FFFFF -> add_sum=0x7F800000. 0x7F800000 + 0xFF800000 -> 0x7FC00000. 0x7FC00001 + 0x3F800000 -> 0x7FC00000.
- Second add_start pulsed while busy -> ignored; exactly one ready pulse. add_start held in the ready cycle -> second request accepted; its result arrives 4 edges later.
- reset_n low for 1 cycle during NORM -> no ready pulse; add_sum=0, add_busy=0. Next request (1.5=0x3FC00000 + 1.5) -> add_sum=0x40400000 with normal latency.
